regdump_ctrl: RTL

REGDUMP_CTRL -- requirements
Module: regdump_ctrl

---
 rtl/regdump_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regdump_ctrl.sv
// Run/dump sequencer: resets the core, runs it for a set number of
// cycles, then streams every register out over a valid/ready port.
module regdump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CYC_W    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CYC_W-1:0] num_cycles,
  output logic             proc_reset,
  output logic             run_en,
  input  logic [4:0]       rs1_proc,
  output logic [4:0]       rs1_out,
  input  logic [31:0]      data_readRegA,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_reg,
  output logic [31:0]      dump_data,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRST, S_RUN, S_ADDR, S_DUMP, S_DONE
  } state_t;

  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CYC_W-1:0] r_lat;
  logic [CYC_W-1:0] r_cnt;
  logic [4:0]       r_idx;
  logic [4:0]       r_dreg;
  logic [31:0]      r_ddata;
  logic             w_start_ok;
  logic             w_run_last;
  logic             w_hs;

  assign w_start_ok = start &&
    (r_state == S_IDLE || r_state == S_DONE);
  assign w_run_last = (r_cnt == r_lat - CYC_W'(1));
  assign w_hs       = (r_state == S_DUMP) && dump_ready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_PRST;
      S_PRST: w_next = (r_lat != '0) ? S_RUN : S_ADDR;
      S_RUN:  if (w_run_last) w_next = S_ADDR;
      S_ADDR: w_next = S_DUMP;
      S_DUMP: begin
        if (w_hs) w_next = (r_idx == LAST) ? S_DONE : S_ADDR;
      end
      S_DONE: if (start) w_next = S_PRST;
      default: w_next = S_IDLE;
    endcase
  end

  // Index is cleared in PRST so a restart from DONE dumps from r0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lat   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dreg  <= '0;
      r_ddata <= '0;
    end else begin
      if (w_start_ok) begin
        r_lat <= num_cycles;
        r_cnt <= '0;
      end
      if (r_state == S_PRST) r_idx <= '0;
      if (r_state == S_RUN)  r_cnt <= r_cnt + CYC_W'(1);
      if (r_state == S_ADDR) begin
        r_dreg  <= r_idx;
        r_ddata <= data_readRegA;
      end
      if (w_hs && r_idx != LAST) r_idx <= r_idx + 5'd1;
    end
  end

  always_comb begin
    proc_reset = 1'b0;
    run_en     = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    rs1_out    = rs1_proc;
    unique case (r_state)
      S_PRST: begin
        proc_reset = 1'b1;
        busy       = 1'b1;
      end
      S_RUN: begin
        run_en = 1'b1;
        busy   = 1'b1;
      end
      S_ADDR: begin
        rs1_out = r_idx;
        busy    = 1'b1;
      end
      S_DUMP: begin
        rs1_out    = r_idx;
        dump_valid = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign dump_reg    = r_dreg;
  assign dump_data   = r_ddata;
  assign cycle_count = r_cnt;

endmodule
